// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared types and sizes for the regfile hazard/write-port control
package rv_pipe_pkg;

    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic          wen;
        logic          load;
    } stage_slot_t;

    // A source matches a producer only if it is really read and is not x0.
    function automatic logic src_hit(input logic used, input logic [AW-1:0] src,
                                     input logic v, input logic wen, input logic [AW-1:0] rd);
        return used & v & wen & (rd == src) & (src != '0);
    endfunction

endpackage

// File: rtl/rf_wport_arb.sv
// rtl/rf_wport_arb.sv - fixed-priority WB/MDU mux for the single regfile write port
module rf_wport_arb
    import rv_pipe_pkg::*;
(
    input  logic            wb_v,
    input  logic            wb_wen,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_wdata,
    input  logic            mdu_wb_valid,
    input  logic [AW-1:0]   mdu_wb_rd,
    input  logic [XLEN-1:0] mdu_wb_data,
    output logic            mdu_wb_ready,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    always_comb begin
        mdu_wb_ready = 1'b0;
        rf_wen       = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        if (wb_v && wb_wen) begin
            rf_wen   = 1'b1;
            rf_waddr = wb_rd;
            rf_wdata = wb_wdata;
        end else if (mdu_wb_valid) begin
            // An MDU result aimed at x0 is consumed but never written.
            mdu_wb_ready = 1'b1;
            rf_wen       = (mdu_wb_rd != '0);
            rf_waddr     = mdu_wb_rd;
            rf_wdata     = mdu_wb_data;
        end
    end

endmodule

// File: rtl/rf_hazard_ctrl.sv
// rtl/rf_hazard_ctrl.sv - ID stall, WB bypass, EX forwarding and regfile write-port control
module rf_hazard_ctrl
    import rv_pipe_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_rd_wen,
    input  logic            id_is_load,
    input  logic            id_is_mdu,
    input  logic            ex_flush,
    input  logic [XLEN-1:0] wb_wdata,
    input  logic            mdu_wb_valid,
    input  logic [AW-1:0]   mdu_wb_rd,
    input  logic [XLEN-1:0] mdu_wb_data,
    output logic            mdu_wb_ready,
    output logic            id_stall,
    output logic            id_rs1_byp,
    output logic            id_rs2_byp,
    output fwd_sel_e        ex_fwd_rs1,
    output fwd_sel_e        ex_fwd_rs2,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    stage_slot_t     ex_q, ex_d;
    logic            mem_v_q, mem_wen_q, wb_v_q, wb_wen_q;
    logic [AW-1:0]   mem_rd_q, wb_rd_q;
    logic [NREG-1:1] busy_q, busy_d;
    logic [NREG-1:0] busy_all;
    logic            mdu_busy_q, mdu_busy_d;
    logic            rs1_ex, rs2_ex, rs1_mem, rs2_mem;
    logic            load_use, raw_mdu, waw_mdu, mdu_full, issue;

    function automatic fwd_sel_e pick_fwd(input logic hit_ex, input logic hit_mem);
        if (hit_ex)
            return FWD_MEM;
        if (hit_mem)
            return FWD_WB;
        return FWD_REG;
    endfunction

    assign busy_all = {busy_q, 1'b0};

    assign rs1_ex  = src_hit(id_rs1_used, id_rs1, ex_q.v, ex_q.wen, ex_q.rd);
    assign rs2_ex  = src_hit(id_rs2_used, id_rs2, ex_q.v, ex_q.wen, ex_q.rd);
    assign rs1_mem = src_hit(id_rs1_used, id_rs1, mem_v_q, mem_wen_q, mem_rd_q);
    assign rs2_mem = src_hit(id_rs2_used, id_rs2, mem_v_q, mem_wen_q, mem_rd_q);

    // The regfile does not write-before-read, so ID takes the WB value directly.
    assign id_rs1_byp = src_hit(id_rs1_used, id_rs1, wb_v_q, wb_wen_q, wb_rd_q);
    assign id_rs2_byp = src_hit(id_rs2_used, id_rs2, wb_v_q, wb_wen_q, wb_rd_q);

    assign load_use = (rs1_ex | rs2_ex) & ex_q.load;
    assign raw_mdu  = (id_rs1_used & busy_all[id_rs1]) | (id_rs2_used & busy_all[id_rs2]);
    assign waw_mdu  = id_rd_wen & busy_all[id_rd];
    assign mdu_full = id_is_mdu & mdu_busy_q;

    assign id_stall = id_valid & ~ex_flush & (load_use | raw_mdu | waw_mdu | mdu_full);
    assign issue    = id_valid & ~ex_flush & ~id_stall;

    always_comb begin
        ex_d = '0;
        if (issue) begin
            ex_d.v    = 1'b1;
            ex_d.rd   = id_rd;
            ex_d.wen  = id_rd_wen & ~id_is_mdu & (id_rd != '0);
            ex_d.load = id_is_load;
        end
    end

    // Clear before set so a same-cycle issue keeps the MDU marked busy.
    always_comb begin
        busy_d = busy_q;
        if (mdu_wb_ready && (mdu_wb_rd != '0))
            busy_d[mdu_wb_rd] = 1'b0;
        if (issue && id_is_mdu && (id_rd != '0))
            busy_d[id_rd] = 1'b1;
    end

    assign mdu_busy_d = (mdu_busy_q & ~mdu_wb_ready) | (issue & id_is_mdu);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= '0;
            mem_v_q    <= 1'b0;
            mem_wen_q  <= 1'b0;
            mem_rd_q   <= '0;
            wb_v_q     <= 1'b0;
            wb_wen_q   <= 1'b0;
            wb_rd_q    <= '0;
            busy_q     <= '0;
            mdu_busy_q <= 1'b0;
            ex_fwd_rs1 <= FWD_REG;
            ex_fwd_rs2 <= FWD_REG;
        end else begin
            ex_q       <= ex_d;
            mem_v_q    <= ex_q.v;
            mem_wen_q  <= ex_q.wen;
            mem_rd_q   <= ex_q.rd;
            wb_v_q     <= mem_v_q;
            wb_wen_q   <= mem_wen_q;
            wb_rd_q    <= mem_rd_q;
            busy_q     <= busy_d;
            mdu_busy_q <= mdu_busy_d;
            ex_fwd_rs1 <= issue ? pick_fwd(rs1_ex, rs1_mem) : FWD_REG;
            ex_fwd_rs2 <= issue ? pick_fwd(rs2_ex, rs2_mem) : FWD_REG;
        end
    end

    rf_wport_arb u_wport_arb (
        .wb_v         (wb_v_q),
        .wb_wen       (wb_wen_q),
        .wb_rd        (wb_rd_q),
        .wb_wdata     (wb_wdata),
        .mdu_wb_valid (mdu_wb_valid),
        .mdu_wb_rd    (mdu_wb_rd),
        .mdu_wb_data  (mdu_wb_data),
        .mdu_wb_ready (mdu_wb_ready),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
    );

endmodule

// File: tb/tb_rf_hazard_ctrl.sv
// tb/tb_rf_hazard_ctrl.sv - directed and randomized checks of rf_hazard_ctrl against an in-flight list model
module tb_rf_hazard_ctrl;
    import rv_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_rs1_used, id_rs2_used, id_rd_wen, id_is_load, id_is_mdu, ex_flush;
    logic [4:0]  id_rs1, id_rs2, id_rd, mdu_wb_rd, rf_waddr;
    logic [31:0] wb_wdata, mdu_wb_data, rf_wdata;
    logic        mdu_wb_valid, mdu_wb_ready, id_stall, id_rs1_byp, id_rs2_byp, rf_wen;
    fwd_sel_e    ex_fwd_rs1, ex_fwd_rs2;

    always #5 clk = ~clk;

    rf_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_wen(id_rd_wen),
        .id_is_load(id_is_load), .id_is_mdu(id_is_mdu), .ex_flush(ex_flush), .wb_wdata(wb_wdata),
        .mdu_wb_valid(mdu_wb_valid), .mdu_wb_rd(mdu_wb_rd), .mdu_wb_data(mdu_wb_data),
        .mdu_wb_ready(mdu_wb_ready), .id_stall(id_stall), .id_rs1_byp(id_rs1_byp),
        .id_rs2_byp(id_rs2_byp), .ex_fwd_rs1(ex_fwd_rs1), .ex_fwd_rs2(ex_fwd_rs2),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    typedef struct {
        bit v;
        int rd;
        bit wen;
        bit ld;
    } rec_t;

    // pipe[0] is the youngest in-flight instruction (EX), pipe[2] the oldest (WB).
    rec_t pipe[$];
    bit   m_busy[32];
    bit   m_mdub;
    int   m_f1, m_f2;
    bit   e_stall, e_b1, e_b2, e_wen, e_ready, e_issue;
    int   e_waddr, e_fn1, e_fn2;
    logic [31:0] e_wdata;
    logic s_stall, s_b2, s_wen, s_ready;
    logic [4:0] s_waddr;
    bit   auto_mdu, pend;
    int   pcnt, prd;
    logic [31:0] pdata;
    int   checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        rec_t bub;
        bub = '{v: 1'b0, rd: 0, wen: 1'b0, ld: 1'b0};
        pipe.delete();
        repeat (3) pipe.push_back(bub);
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_mdub = 1'b0;
        m_f1 = 0;
        m_f2 = 0;
        pend = 1'b0;
    endtask

    function automatic bit match(bit used, int src, int k);
        return used && pipe[k].v && pipe[k].wen && pipe[k].rd == src && src != 0;
    endfunction

    function automatic int fwd_of(bit used, int src);
        if (match(used, src, 0)) return 1;
        if (match(used, src, 1)) return 2;
        return 0;
    endfunction

    task automatic model_comb();
        int r1, r2, rd;
        bit a, b, c, d;
        r1 = int'(id_rs1);
        r2 = int'(id_rs2);
        rd = int'(id_rd);
        a = (match(id_rs1_used, r1, 0) || match(id_rs2_used, r2, 0)) && pipe[0].ld;
        b = (id_rs1_used && m_busy[r1]) || (id_rs2_used && m_busy[r2]);
        c = id_rd_wen && m_busy[rd];
        d = id_is_mdu && m_mdub;
        e_stall = id_valid && !ex_flush && (a || b || c || d);
        e_issue = id_valid && !ex_flush && !e_stall;
        e_b1 = match(id_rs1_used, r1, 2);
        e_b2 = match(id_rs2_used, r2, 2);
        e_fn1 = e_issue ? fwd_of(id_rs1_used, r1) : 0;
        e_fn2 = e_issue ? fwd_of(id_rs2_used, r2) : 0;
        if (pipe[2].v && pipe[2].wen) begin
            e_wen = 1'b1; e_waddr = pipe[2].rd; e_wdata = wb_wdata; e_ready = 1'b0;
        end else begin
            e_ready = mdu_wb_valid;
            e_wen = mdu_wb_valid && mdu_wb_rd != 0;
            e_waddr = int'(mdu_wb_rd);
            e_wdata = mdu_wb_data;
        end
    endtask

    task automatic model_seq();
        rec_t r;
        if (!rst_n) begin
            reset_model();
            return;
        end
        r = '{v: 1'b0, rd: 0, wen: 1'b0, ld: 1'b0};
        if (e_issue)
            r = '{v: 1'b1, rd: int'(id_rd), wen: id_rd_wen && !id_is_mdu && id_rd != 0, ld: id_is_load};
        pipe.push_front(r);
        pipe.delete(3);
        m_f1 = e_fn1;
        m_f2 = e_fn2;
        if (e_ready) begin
            if (mdu_wb_rd != 0) m_busy[int'(mdu_wb_rd)] = 1'b0;
            m_mdub = 1'b0;
        end
        if (e_issue && id_is_mdu) begin
            if (id_rd != 0) m_busy[int'(id_rd)] = 1'b1;
            m_mdub = 1'b1;
        end
        if (auto_mdu) begin
            if (e_ready) pend = 1'b0;
            if (e_issue && id_is_mdu) begin
                pend = 1'b1; prd = int'(id_rd); pcnt = $urandom_range(0, 5); pdata = $urandom;
            end else if (pend && pcnt > 0) begin
                pcnt--;
            end
        end
    endtask

    // One clock: comb outputs checked mid-cycle, registered selects just after the edge.
    task automatic cyc();
        #4;
        if (!rst_n) reset_model();
        model_comb();
        s_stall = id_stall; s_b2 = id_rs2_byp; s_wen = rf_wen; s_waddr = rf_waddr; s_ready = mdu_wb_ready;
        check("id_stall", 32'(id_stall), 32'(e_stall));
        check("id_rs1_byp", 32'(id_rs1_byp), 32'(e_b1));
        check("id_rs2_byp", 32'(id_rs2_byp), 32'(e_b2));
        check("rf_wen", 32'(rf_wen), 32'(e_wen));
        check("mdu_wb_ready", 32'(mdu_wb_ready), 32'(e_ready));
        if (e_wen) begin
            check("rf_waddr", 32'(rf_waddr), 32'(e_waddr));
            check("rf_wdata", rf_wdata, e_wdata);
        end
        @(posedge clk);
        model_seq();
        #1;
        check("ex_fwd_rs1", 32'(ex_fwd_rs1), 32'(m_f1));
        check("ex_fwd_rs2", 32'(ex_fwd_rs2), 32'(m_f2));
        if (auto_mdu) begin
            mdu_wb_valid = pend && pcnt == 0;
            mdu_wb_rd = 5'(prd);
            mdu_wb_data = pdata;
        end
    endtask

    task automatic id_set(input int v, input int r1, input int u1, input int r2, input int u2,
                          input int rd, input int w, input int ld, input int md);
        id_valid = 1'(v); id_rs1 = 5'(r1); id_rs1_used = 1'(u1); id_rs2 = 5'(r2); id_rs2_used = 1'(u2);
        id_rd = 5'(rd); id_rd_wen = 1'(w); id_is_load = 1'(ld); id_is_mdu = 1'(md);
    endtask

    task automatic nop();
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; auto_mdu = 1'b0; prd = 0; pcnt = 0; pdata = '0;
        nop(); ex_flush = 1'b0; wb_wdata = 32'h1234_5678;
        mdu_wb_valid = 1'b0; mdu_wb_rd = '0; mdu_wb_data = '0;
        reset_model();
        @(posedge clk); #1;
        cyc();
        check("reset_fwd1", 32'(ex_fwd_rs1), 32'd0);
        check("reset_rf_wen", 32'(s_wen), 32'd0);
        rst_n = 1'b1;

        // 1: EX producer forwarded from MEM
        id_set(1, 0, 0, 0, 0, 5, 1, 0, 0); cyc();
        id_set(1, 5, 1, 5, 1, 6, 1, 0, 0); cyc();
        check("t1_stall", 32'(s_stall), 32'd0);
        check("t1_fwd1", 32'(ex_fwd_rs1), 32'd1);
        check("t1_fwd2", 32'(ex_fwd_rs2), 32'd1);

        // 2: load-use costs exactly one bubble
        id_set(1, 0, 0, 0, 0, 7, 1, 1, 0); cyc();
        id_set(1, 7, 1, 0, 0, 8, 1, 0, 0); cyc();
        check("t2_stall", 32'(s_stall), 32'd1);
        cyc();
        check("t2_stall_drop", 32'(s_stall), 32'd0);
        check("t2_fwd1", 32'(ex_fwd_rs1), 32'd2);

        // 3: RAW on MDU result, WB wins the port first
        id_set(1, 0, 0, 0, 0, 3, 1, 0, 0); cyc();
        id_set(1, 0, 0, 0, 0, 9, 1, 0, 1); cyc();
        id_set(1, 9, 1, 0, 0, 10, 1, 0, 0); cyc();
        check("t3_stall0", 32'(s_stall), 32'd1);
        mdu_wb_valid = 1'b1; mdu_wb_rd = 5'd9; mdu_wb_data = 32'hD1D0_0009; cyc();
        check("t3_stall1", 32'(s_stall), 32'd1);
        check("t3_waddr_wb", 32'(s_waddr), 32'd3);
        check("t3_ready_lose", 32'(s_ready), 32'd0);
        cyc();
        check("t3_waddr_mdu", 32'(s_waddr), 32'd9);
        check("t3_ready_win", 32'(s_ready), 32'd1);
        check("t3_stall2", 32'(s_stall), 32'd1);
        mdu_wb_valid = 1'b0; cyc();
        check("t3_stall_drop", 32'(s_stall), 32'd0);

        // 4: x0 never creates a dependence or a write
        id_set(1, 0, 0, 0, 0, 0, 1, 0, 0); cyc();
        id_set(1, 0, 1, 0, 1, 0, 1, 0, 0); cyc();
        check("t4_stall", 32'(s_stall), 32'd0);
        check("t4_fwd1", 32'(ex_fwd_rs1), 32'd0);
        id_set(1, 0, 0, 0, 0, 0, 1, 0, 1); cyc();
        nop(); mdu_wb_valid = 1'b1; mdu_wb_rd = 5'd0; cyc();
        check("t4_ready_x0", 32'(s_ready), 32'd1);
        check("t4_rf_wen_x0", 32'(s_wen), 32'd0);
        mdu_wb_valid = 1'b0; cyc();

        // 5: flush masks load-use; WB bypass into ID
        id_set(1, 0, 0, 0, 0, 4, 1, 0, 0); cyc();
        nop(); cyc();
        id_set(1, 0, 0, 0, 0, 7, 1, 1, 0); cyc();
        id_set(1, 7, 1, 4, 1, 8, 1, 0, 0); ex_flush = 1'b1; cyc();
        check("t5_stall", 32'(s_stall), 32'd0);
        check("t5_byp2", 32'(s_b2), 32'd1);
        check("t5_fwd1", 32'(ex_fwd_rs1), 32'd0);
        ex_flush = 1'b0; nop(); cyc();

        // 6: reset drops a pending MDU dependence
        id_set(1, 0, 0, 0, 0, 9, 1, 0, 1); cyc();
        nop(); cyc();
        rst_n = 1'b0; cyc();
        check("t6_rf_wen", 32'(s_wen), 32'd0);
        check("t6_fwd1", 32'(ex_fwd_rs1), 32'd0);
        rst_n = 1'b1;
        id_set(1, 9, 1, 0, 0, 10, 1, 0, 0); cyc();
        check("t6_stall", 32'(s_stall), 32'd0);

        // Randomized traffic with a self-timed MDU
        nop(); cyc();
        auto_mdu = 1'b1;
        for (int i = 0; i < 500; i++) begin
            id_valid    = 1'($urandom_range(0, 9) != 0);
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            id_rd       = 5'($urandom_range(0, 7));
            id_rd_wen   = 1'($urandom_range(0, 3) != 0);
            id_is_mdu   = 1'($urandom_range(0, 7) == 0);
            id_is_load  = 1'(!id_is_mdu && $urandom_range(0, 3) == 0);
            ex_flush    = 1'($urandom_range(0, 9) == 0);
            wb_wdata    = $urandom;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
